// File: rtl/dart_lb_pkg.sv
// ============================================================================
// Module : dart_lb_pkg
// Brief  : Shared types and helpers for the dart UART loopback engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dart_lb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FILL   = 2'd2,
    DRAIN  = 2'd3
  } lb_state_t;

  localparam int LB_STATE_W = 2;

  // Occupancy needs one extra code so that "full" (== depth) is representable.
  function automatic int lb_level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dart_uart_loopback_if.sv
// ============================================================================
// Module : dart_uart_loopback_if
// Brief  : rx/tx user-side word handshake between dartport and the loopback.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dart_uart_loopback_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ack;

  modport master (
    output rx_data, rx_valid, tx_ack,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ack,
    output tx_data, tx_valid
  );
endinterface

`default_nettype wire

// File: rtl/dart_sync_fifo.sv
// ============================================================================
// Module : dart_sync_fifo
// Brief  : Single-clock first-word-fall-through FIFO, async active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dart_sync_fifo
  import dart_lb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128
) (
  input  wire logic                          clock,
  input  wire logic                          reset_n,
  input  wire logic                          wr_en,
  input  wire logic [WIDTH-1:0]              din,
  input  wire logic                          rd_en,
  output logic      [WIDTH-1:0]              dout,
  output logic                               empty,
  output logic                               full,
  output logic      [lb_level_w(DEPTH)-1:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lb_level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign empty   = (r_count == '0);
  assign full    = (r_count == LW'(DEPTH));
  assign level   = r_count;
  assign dout    = r_mem[r_rd_ptr];
  // A write into a full FIFO is legal only when the head leaves on the same edge.
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);

  always_ff @(posedge clock) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + LW'(1);
      end else if (w_do_rd && !w_do_wr) begin
        r_count <= r_count - LW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dart_uart_loopback.sv
// ============================================================================
// Module : dart_uart_loopback
// Brief  : UART word loopback (stream echo or batch collect/return) over a
//          FWFT FIFO. Optional statistics counters under DART_LB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dart_uart_loopback
  import dart_lb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 128,
  parameter int BATCH_LEN = 100
) (
  input  wire logic                          clock,
  input  wire logic                          reset_n,
  input  wire logic                          enable,
  input  wire logic                          batch_mode,
  input  wire logic                          clear_flags,
  dart_uart_loopback_if.slave                lb,
  output logic      [lb_level_w(DEPTH)-1:0]  level,
  output logic      [LB_STATE_W-1:0]         state,
  output logic                               dropped
`ifdef DART_LB_STATS_EN
  ,
  output logic      [15:0]                   rx_count,
  output logic      [15:0]                   tx_count,
  output logic      [7:0]                    drop_count
`endif
);

  localparam int            LW           = lb_level_w(DEPTH);
  localparam logic [LW-1:0] C_BATCH_LAST = LW'(BATCH_LEN - 1);

  lb_state_t        r_state;
  lb_state_t        w_state_nxt;
  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_dout;
  logic [LW-1:0]    w_level;
  logic [LW-1:0]    r_batch_cnt;
  logic             r_dropped;
  logic             w_tx_phase;
  logic             w_rx_phase;
  logic             w_tx_valid;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;
  logic             w_batch_done;

  assign w_tx_phase   = (r_state == STREAM) || (r_state == DRAIN);
  assign w_rx_phase   = (r_state == STREAM) || (r_state == FILL);
  assign w_tx_valid   = enable && !w_empty && w_tx_phase;
  assign w_pop        = lb.tx_ack && w_tx_valid;
  assign w_accept     = lb.rx_valid && enable && w_rx_phase && (!w_full || w_pop);
  assign w_drop       = lb.rx_valid && !w_accept;
  assign w_batch_done = (r_state == FILL) && w_accept && (r_batch_cnt == C_BATCH_LAST);

  dart_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (w_accept),
    .din     (lb.rx_data),
    .rd_en   (w_pop),
    .dout    (w_dout),
    .empty   (w_empty),
    .full    (w_full),
    .level   (w_level)
  );

  // Stale RAM contents are masked so the head reads zero while empty.
  assign lb.tx_data  = w_empty ? '0 : w_dout;
  assign lb.tx_valid = w_tx_valid;
  assign level       = w_level;
  assign state       = r_state;
  assign dropped     = r_dropped;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (enable) begin
      case (r_state)
        IDLE:    w_state_nxt = batch_mode ? FILL : STREAM;
        // Leave stream only once every echoed word has gone out.
        STREAM:  if (batch_mode && w_empty && !w_accept) w_state_nxt = IDLE;
        FILL:    if (w_batch_done) w_state_nxt = DRAIN;
        DRAIN:   if (w_pop && (w_level == LW'(1))) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_batch_cnt <= '0;
    end else if (w_batch_done) begin
      r_batch_cnt <= '0;
    end else if ((r_state == FILL) && w_accept) begin
      r_batch_cnt <= r_batch_cnt + LW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dropped <= 1'b0;
    end else if (clear_flags) begin
      r_dropped <= 1'b0;
    end else if (w_drop) begin
      r_dropped <= 1'b1;
    end
  end

`ifdef DART_LB_STATS_EN
  logic [15:0] r_rx_count;
  logic [15:0] r_tx_count;
  logic [7:0]  r_drop_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_count   <= '0;
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else if (clear_flags) begin
      r_rx_count   <= '0;
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_accept) r_rx_count   <= r_rx_count + 16'd1;
      if (w_pop)    r_tx_count   <= r_tx_count + 16'd1;
      if (w_drop)   r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign rx_count   = r_rx_count;
  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dart_uart_loopback.sv
// ============================================================================
// Module : tb_dart_uart_loopback
// Brief  : Self-checking bench for dart_uart_loopback against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dart_uart_loopback;

  localparam int WIDTH = 16;
  localparam int DEPTH = 128;
  localparam int BATCH = 100;
  localparam int LW    = 8;

  logic clock       = 1'b0;
  logic reset_n     = 1'b0;
  logic enable      = 1'b0;
  logic batch_mode  = 1'b0;
  logic clear_flags = 1'b0;

  wire [LW-1:0] level;
  wire [1:0]    state;
  wire          dropped;
`ifdef DART_LB_STATS_EN
  wire [15:0]   rx_count;
  wire [15:0]   tx_count;
  wire [7:0]    drop_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] q[$];

  always #5 clock = ~clock;

  dart_uart_loopback_if #(.WIDTH(WIDTH)) lb_if ();

  dart_uart_loopback #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .BATCH_LEN (BATCH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .batch_mode  (batch_mode),
    .clear_flags (clear_flags),
    .lb          (lb_if.slave),
    .level       (level),
    .state       (state),
    .dropped     (dropped)
`ifdef DART_LB_STATS_EN
    ,
    .rx_count    (rx_count),
    .tx_count    (tx_count),
    .drop_count  (drop_count)
`endif
  );

  task automatic drive(input logic rxv, input logic [WIDTH-1:0] d, input logic ack);
    lb_if.rx_valid = rxv;
    lb_if.rx_data  = d;
    lb_if.tx_ack   = ack;
    @(posedge clock);
    #1;
    lb_if.rx_valid = 1'b0;
    lb_if.tx_ack   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clock);
    #1;
    clear_flags = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (lb_if.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", lb_if.tx_valid); end
    checks++; if (lb_if.tx_data !== 16'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0000", lb_if.tx_data); end
    checks++; if (level !== 8'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", dropped); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    // a word offered while still IDLE is dropped; FSM moves to STREAM
    drive(1'b1, 16'h1234, 1'b0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL idle_to_stream state=%0d exp=1", state); end
    checks++; if (dropped !== 1'b1 || level !== 8'd0) begin failures++; $display("FAIL idle_drop dropped=%b level=%0d exp 1/0", dropped, level); end
    pulse_clear();
    checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL clear_flags dropped=%b exp=0", dropped); end
  endtask

  task automatic test_stream();
    logic rxv, ack, pop;
    logic [WIDTH-1:0] d;
    drive(1'b1, 16'hA5A5, 1'b0);
    checks++; if (lb_if.tx_valid !== 1'b1 || lb_if.tx_data !== 16'hA5A5 || level !== 8'd1) begin failures++; $display("FAIL stream_first valid=%b data=%h level=%0d exp 1/a5a5/1", lb_if.tx_valid, lb_if.tx_data, level); end
    drive(1'b1, 16'h0001, 1'b0);
    checks++; if (lb_if.tx_data !== 16'hA5A5 || level !== 8'd2) begin failures++; $display("FAIL stream_second data=%h level=%0d exp a5a5/2", lb_if.tx_data, level); end
    drive(1'b0, 16'h0, 1'b1);
    checks++; if (lb_if.tx_data !== 16'h0001 || level !== 8'd1) begin failures++; $display("FAIL stream_pop1 data=%h level=%0d exp 0001/1", lb_if.tx_data, level); end
    drive(1'b0, 16'h0, 1'b1);
    checks++; if (lb_if.tx_valid !== 1'b0 || level !== 8'd0) begin failures++; $display("FAIL stream_pop2 valid=%b level=%0d exp 0/0", lb_if.tx_valid, level); end
    for (int i = 0; i < 40; i++) begin
      rxv = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      pop = ack && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (rxv && (q.size() < DEPTH)) q.push_back(d);
      drive(rxv, d, ack);
      checks++; if (level !== LW'(q.size())) begin failures++; $display("FAIL stream_rand_level i=%0d got=%0d exp=%0d", i, level, q.size()); end
      checks++; if (lb_if.tx_valid !== (q.size() != 0)) begin failures++; $display("FAIL stream_rand_valid i=%0d got=%b exp=%b", i, lb_if.tx_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (lb_if.tx_data !== q[0]) begin failures++; $display("FAIL stream_rand_data i=%0d got=%h exp=%h", i, lb_if.tx_data, q[0]); end
      end
    end
    while (q.size() > 0) begin
      void'(q.pop_front());
      drive(1'b0, 16'h0, 1'b1);
    end
    checks++; if (level !== 8'd0 || dropped !== 1'b0) begin failures++; $display("FAIL stream_end level=%0d dropped=%b exp 0/0", level, dropped); end
  endtask

  task automatic test_enable_freeze();
    logic [WIDTH-1:0] w;
    w = 16'($urandom);
    drive(1'b1, w, 1'b0);
    enable = 1'b0;
    #1;
    checks++; if (lb_if.tx_valid !== 1'b0) begin failures++; $display("FAIL freeze_tx_valid got=%b exp=0", lb_if.tx_valid); end
    drive(1'b1, 16'($urandom), 1'b1);
    checks++; if (level !== 8'd1 || dropped !== 1'b1 || state !== 2'd1) begin failures++; $display("FAIL freeze_hold level=%0d dropped=%b state=%0d exp 1/1/1", level, dropped, state); end
    pulse_clear();
    // clear has priority over a drop in the same cycle
    clear_flags = 1'b1;
    drive(1'b1, 16'($urandom), 1'b0);
    clear_flags = 1'b0;
    checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL clear_priority dropped=%b exp=0", dropped); end
    enable = 1'b1;
    #1;
    checks++; if (lb_if.tx_valid !== 1'b1 || lb_if.tx_data !== w) begin failures++; $display("FAIL freeze_resume valid=%b data=%h exp 1/%h", lb_if.tx_valid, lb_if.tx_data, w); end
    drive(1'b0, 16'h0, 1'b1);
    checks++; if (level !== 8'd0) begin failures++; $display("FAIL freeze_drain level=%0d exp=0", level); end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < DEPTH + 2; i++) begin
      d = 16'($urandom);
      if (q.size() < DEPTH) q.push_back(d);
      drive(1'b1, d, 1'b0);
    end
    checks++; if (level !== LW'(DEPTH) || dropped !== 1'b1) begin failures++; $display("FAIL overflow level=%0d dropped=%b exp %0d/1", level, dropped, DEPTH); end
    pulse_clear();
    d = 16'($urandom);
    void'(q.pop_front());
    q.push_back(d);
    drive(1'b1, d, 1'b1);
    checks++; if (level !== LW'(DEPTH) || dropped !== 1'b0 || lb_if.tx_data !== q[0]) begin failures++; $display("FAIL full_push_pop level=%0d dropped=%b data=%h exp %0d/0/%h", level, dropped, lb_if.tx_data, DEPTH, q[0]); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (lb_if.tx_valid !== 1'b1 || lb_if.tx_data !== q[0]) begin failures++; $display("FAIL overflow_drain i=%0d valid=%b data=%h exp 1/%h", i, lb_if.tx_valid, lb_if.tx_data, q[0]); end
      void'(q.pop_front());
      drive(1'b0, 16'h0, 1'b1);
    end
    drive(1'b0, 16'h0, 1'b1);
    checks++; if (level !== 8'd0 || lb_if.tx_valid !== 1'b0) begin failures++; $display("FAIL ack_when_empty level=%0d valid=%b exp 0/0", level, lb_if.tx_valid); end
  endtask

  task automatic wait_fill(input string tag);
    int n;
    n = 0;
    while (state !== 2'd2 && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL %s_enter_fill state=%0d exp=2", tag, state); end
  endtask

  task automatic fill_batch(input string tag);
    logic [WIDTH-1:0] d;
    for (int i = 1; i <= BATCH; i++) begin
      d = 16'($urandom);
      q.push_back(d);
      drive(1'b1, d, 1'b0);
      if (i < BATCH) begin
        checks++; if (lb_if.tx_valid !== 1'b0 || state !== 2'd2) begin failures++; $display("FAIL %s_fill i=%0d valid=%b state=%0d exp 0/2", tag, i, lb_if.tx_valid, state); end
      end
    end
    checks++; if (state !== 2'd3 || lb_if.tx_valid !== 1'b1 || lb_if.tx_data !== q[0] || level !== LW'(BATCH)) begin failures++; $display("FAIL %s_drain_entry state=%0d valid=%b data=%h level=%0d exp 3/1/%h/%0d", tag, state, lb_if.tx_valid, lb_if.tx_data, level, q[0], BATCH); end
  endtask

  task automatic test_batch();
    pulse_clear();
    batch_mode = 1'b1;
    wait_fill("batch");
    fill_batch("batch");
    drive(1'b1, 16'($urandom), 1'b0);
    drive(1'b1, 16'($urandom), 1'b0);
    checks++; if (dropped !== 1'b1 || level !== LW'(BATCH)) begin failures++; $display("FAIL drain_drop dropped=%b level=%0d exp 1/%0d", dropped, level, BATCH); end
    for (int i = 0; i < BATCH; i++) begin
      checks++; if (lb_if.tx_data !== q[0]) begin failures++; $display("FAIL batch_order i=%0d got=%h exp=%h", i, lb_if.tx_data, q[0]); end
      void'(q.pop_front());
      drive(1'b0, 16'h0, 1'b1);
    end
    checks++; if (state !== 2'd0 || level !== 8'd0 || lb_if.tx_valid !== 1'b0) begin failures++; $display("FAIL batch_idle state=%0d level=%0d valid=%b exp 0/0/0", state, level, lb_if.tx_valid); end
`ifdef DART_LB_STATS_EN
    checks++; if (rx_count !== 16'd100 || tx_count !== 16'd100 || drop_count !== 8'd2) begin failures++; $display("FAIL stats rx=%0d tx=%0d drop=%0d exp 100/100/2", rx_count, tx_count, drop_count); end
    pulse_clear();
    checks++; if (rx_count !== 16'd0 || tx_count !== 16'd0 || drop_count !== 8'd0) begin failures++; $display("FAIL stats_clear rx=%0d tx=%0d drop=%0d exp 0/0/0", rx_count, tx_count, drop_count); end
`endif
  endtask

  task automatic test_reset_mid_drain();
    wait_fill("rst");
    fill_batch("rst");
    for (int i = 0; i < 3; i++) begin
      void'(q.pop_front());
      drive(1'b0, 16'h0, 1'b1);
    end
    #2;
    reset_n = 1'b0;
    q.delete();
    #1;
    checks++; if (lb_if.tx_valid !== 1'b0 || level !== 8'd0 || state !== 2'd0) begin failures++; $display("FAIL async_reset valid=%b level=%0d state=%0d exp 0/0/0", lb_if.tx_valid, level, state); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    wait_fill("post_rst");
  endtask

  initial begin
    lb_if.rx_valid = 1'b0;
    lb_if.rx_data  = '0;
    lb_if.tx_ack   = 1'b0;
    test_reset();
    test_stream();
    test_enable_freeze();
    test_overflow();
    test_batch();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
